// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit every two cycles.
// Define DIV_SIGNED_EN for two's-complement operands with a sign FIXUP state.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Execute,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    TRIAL = 3'd3,
    FIXUP = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] a_new;
  logic [WIDTH-1:0] q_new;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             last;

`ifdef DIV_SIGNED_EN
  logic sq_q, sq_d;
  logic sr_q, sr_d;

  // Most-negative input wraps to 2^(WIDTH-1), read as unsigned.
  assign dvd_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
  assign dvs_mag = Divisor[WIDTH-1]  ? -Divisor  : Divisor;
`else
  assign dvd_mag = Dividend;
  assign dvs_mag = Divisor;
`endif

  assign diff  = {1'b0, a_q} - {1'b0, m_q};
  assign qbit  = ~diff[WIDTH];
  assign a_new = qbit ? diff[WIDTH-1:0] : a_q;
  assign q_new = {q_q[WIDTH-1:1], qbit};
  assign last  = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
      sq_q    <= sq_d;
      sr_q    <= sr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
    sq_d    = sq_q;
    sr_d    = sr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (Execute) state_d = LOAD;
      end
      LOAD: begin
        q_d   = dvd_mag;
        m_d   = dvs_mag;
        a_d   = '0;
        cnt_d = '0;
        dz_d  = (Divisor == '0);
`ifdef DIV_SIGNED_EN
        sq_d  = Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
        sr_d  = Dividend[WIDTH-1];
`endif
        if (Divisor == '0) begin
          quo_d   = '1;
          rem_d   = Dividend;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = {a_q[WIDTH-2:0], q_q[WIDTH-1]};
        q_d     = {q_q[WIDTH-2:0], 1'b0};
        state_d = TRIAL;
      end
      TRIAL: begin
        a_d   = a_new;
        q_d   = q_new;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
`ifdef DIV_SIGNED_EN
          state_d = FIXUP;
`else
          quo_d   = q_new;
          rem_d   = a_new;
          state_d = DONE;
`endif
        end else begin
          state_d = SHIFT;
        end
      end
`ifdef DIV_SIGNED_EN
      FIXUP: begin
        quo_d   = sq_q ? -q_q : q_q;
        rem_d   = sr_q ? -a_q : a_q;
        state_d = DONE;
      end
`endif
      DONE: begin
        if (!Execute) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy      = (state_q == LOAD) || (state_q == SHIFT) ||
                     (state_q == TRIAL) || (state_q == FIXUP);
  assign Done      = (state_q == DONE);
  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivZero   = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic model.
// Covers latency, busy span, zero divisor, hold, mid-run reset and stray pulses.
module tb_seq_divider;

  localparam int W = 8;
`ifdef DIV_SIGNED_EN
  localparam int LAT = 2 * W + 2;
`else
  localparam int LAT = 2 * W + 1;
`endif

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         Execute;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Busy;
  logic         Done;
  logic         DivZero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Execute   (Execute),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero)
  );

  always #5 Clk = ~Clk;

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish, got hang, want finish");
    $fatal(1, "timeout");
  end

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q,
                                output logic [W-1:0] r,
                                output logic dz);
    int sa, sb;
    dz = (b == 0);
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold, input bit scramble,
                         input string tag);
    logic [W-1:0] eq, er;
    logic         edz;
    logic [W-1:0] prev_q, prev_r;
    int exp_lat, busy_cnt, done_edge, glitches, bad_hold;
    model(a, b, eq, er, edz);
    exp_lat   = (b == 0) ? 1 : LAT;
    busy_cnt  = 0;
    done_edge = -1;
    glitches  = 0;
    @(negedge Clk);
    Dividend = a;
    Divisor  = b;
    Execute  = 1'b1;
    prev_q   = Quotient;
    prev_r   = Remainder;
    @(posedge Clk);
    for (int k = 0; k <= 60; k++) begin
      #1;
      if (Done) begin
        done_edge = k;
        break;
      end
      if (Busy) busy_cnt++;
      if (Quotient !== prev_q || Remainder !== prev_r) glitches++;
      if (scramble && k == 6) begin
        Dividend = W'($urandom);
        Divisor  = W'($urandom);
      end
      @(posedge Clk);
    end
    n_checks++;
    if (done_edge !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", tag, done_edge, exp_lat);
    end
    n_checks++;
    if (busy_cnt !== exp_lat) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_cnt, exp_lat);
    end
    n_checks++;
    if (glitches !== 0) begin
      n_fail++;
      $display("FAIL %s early_output: got %0d changes want 0", tag, glitches);
    end
    n_checks++;
    if (Quotient !== eq || Remainder !== er || DivZero !== edz) begin
      n_fail++;
      $display("FAIL %s result %h/%h: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
               tag, a, b, Quotient, Remainder, DivZero, eq, er, edz);
    end
    if (hold) begin
      bad_hold = 0;
      repeat (40) begin
        @(posedge Clk);
        #1;
        if (!Done || Busy || Quotient !== eq || Remainder !== er) bad_hold++;
      end
      n_checks++;
      if (bad_hold !== 0) begin
        n_fail++;
        $display("FAIL %s hold: got %0d bad cycles want 0", tag, bad_hold);
      end
    end
    @(negedge Clk);
    Execute = 1'b0;
    @(posedge Clk);
    #1;
    n_checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: got done=%b busy=%b want 0 0", tag, Done, Busy);
    end
  endtask

  task automatic test_reset;
    Reset_n  = 1'b0;
    Execute  = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (3) @(posedge Clk);
    #1;
    n_checks++;
    if ({Busy, Done, DivZero, Quotient, Remainder} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got b=%b d=%b z=%b q=%h r=%h want all 0",
               Busy, Done, DivZero, Quotient, Remainder);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got b=%b d=%b want 0 0", Busy, Done);
    end
  endtask

  task automatic test_directed;
    run_div(8'd100, 8'd7,   0, 0, "d100_7");
    run_div(8'd255, 8'd1,   0, 0, "d255_1");
    run_div(8'd3,   8'd10,  0, 0, "d3_10");
    run_div(8'd5,   8'd0,   0, 0, "d5_0");
    run_div(8'd6,   8'd3,   0, 0, "d6_3");
    run_div(8'd0,   8'd255, 0, 0, "d0_255");
    run_div(8'h80,  8'hFF,  0, 0, "d80_ff");
    run_div(8'h80,  8'h01,  0, 0, "d80_01");
`ifdef DIV_SIGNED_EN
    run_div(8'h9C,  8'h07,  0, 0, "sneg100_7");
    run_div(8'd100, 8'hF9,  0, 0, "s100_neg7");
`endif
  endtask

  task automatic test_constants;
    run_div(8'd100, 8'd7, 0, 0, "const100_7");
    n_checks++;
    if (Quotient !== 8'h0E || Remainder !== 8'h02) begin
      n_fail++;
      $display("FAIL const100_7: got q=%h r=%h want q=0e r=02",
               Quotient, Remainder);
    end
  endtask

  task automatic test_hold_scramble;
    run_div(8'd200, 8'd9,  1, 1, "hold_scr");
    run_div(8'd77,  8'd13, 0, 1, "scr2");
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_div(a, b, 0, 0, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_short_pulse;
    int seen;
    seen = 0;
    @(posedge Clk);
    #1 Execute = 1'b1;
    #2 Execute = 1'b0;
    repeat (4) begin
      @(posedge Clk);
      #1;
      if (Busy || Done) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL short_pulse: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_reset_midrun;
    int active;
    @(negedge Clk);
    Dividend = 8'd200;
    Divisor  = 8'd9;
    Execute  = 1'b1;
    @(posedge Clk);
    repeat (9) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    n_checks++;
    if ({Busy, Done, DivZero, Quotient, Remainder} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: got b=%b d=%b z=%b q=%h r=%h want all 0",
               Busy, Done, DivZero, Quotient, Remainder);
    end
    Execute = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    active = 0;
    repeat (5) begin
      @(posedge Clk);
      #1;
      if (Busy || Done) active++;
    end
    n_checks++;
    if (active !== 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %0d active cycles want 0", active);
    end
    run_div(8'd200, 8'd9, 0, 0, "after_reset");
  endtask

  initial begin
    test_reset;
    test_constants;
    test_directed;
    test_hold_scramble;
    test_short_pulse;
    test_random;
    test_reset_midrun;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
